// File: rtl/ddr2_burst_scheduler_pkg.sv
// Shared types and constants for the DDR2 burst scheduler.
// Holds the FSM state encoding, the MIG command opcodes and address-width helpers.
package ddr2_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } sched_state_t;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  // Width of the MIG user-port byte address.
  localparam int MIG_ADDR_W = 30;

  // Natural byte-address width: burst pointer with the in-burst offset bits below it.
  function automatic int sched_addr_w(input int ptr_w, input int ofs_w);
    return ptr_w + ofs_w;
  endfunction

endpackage

// File: rtl/ddr2_burst_scheduler_if.sv
// MIG port-0 user command bundle.
// The scheduler drives it through the master modport; the MIG (or a model) uses slave.
interface ddr2_burst_scheduler_if;

  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [29:0] p0_cmd_byte_addr;
  logic [5:0]  p0_cmd_bl;
  logic        p0_cmd_full;

  modport master (
    output p0_cmd_en,
    output p0_cmd_instr,
    output p0_cmd_byte_addr,
    output p0_cmd_bl,
    input  p0_cmd_full
  );

  modport slave (
    input  p0_cmd_en,
    input  p0_cmd_instr,
    input  p0_cmd_byte_addr,
    input  p0_cmd_bl,
    output p0_cmd_full
  );

endinterface

// File: rtl/ddr2_burst_scheduler_arb.sv
// Two-way round-robin arbiter: req[0] = write engine, req[1] = read engine.
// On a tie the side that did not win last time is chosen.
// After reset the last winner is read, so write wins the first tie.
module ddr2_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] win
);

  logic last_winner_reg;  // 0 = write, 1 = read

  // One-hot winner selection; a tie goes to the side opposite the last winner.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_winner_reg ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  // Remember who won whenever the scheduler commits to a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_reg <= 1'b1;
    end else if (advance && (win != 2'b00)) begin
      last_winner_reg <= win[1];
    end
  end

endmodule

// File: rtl/ddr2_burst_scheduler.sv
// DDR2 circular-FIFO burst scheduler.
// Arbitrates the MIG port-0 command path between a write engine and a read engine.
// It owns the burst pointers and the stored-burst level, so it never writes into a
// full FIFO and never reads from an empty one.
// Optional macro DDR2_SCHED_STATS_EN adds saturating burst and stall counters.
module ddr2_burst_scheduler
  import ddr2_sched_pkg::*;
#(
  parameter int BURST_LEN = 32,
  parameter int PTR_W     = 20,
  parameter int OFS_W     = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   calib_done,
  input  logic                   wr_req,
  output logic                   wr_gnt,
  input  logic                   rd_req,
  output logic                   rd_gnt,
  ddr2_burst_scheduler_if.master mig,
  output logic [PTR_W:0]         level,
  output logic                   full,
  output logic                   empty
`ifdef DDR2_SCHED_STATS_EN
  ,
  output logic [31:0]            wr_bursts,
  output logic [31:0]            rd_bursts,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int             ADDR_FULL_W = sched_addr_w(PTR_W, OFS_W);
  localparam logic [PTR_W:0] LEVEL_MAX   = {1'b1, {PTR_W{1'b0}}};
  localparam logic [5:0]     BL_VAL      = 6'(BURST_LEN - 1);

  sched_state_t                 state_reg, state_next;
  logic [PTR_W-1:0]             wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]               level_reg;
  logic                         is_rd_reg;
  logic [2:0]                   instr_reg;
  logic [MIG_ADDR_W-1:0]        addr_reg;
  logic                         cmd_en_reg, wr_gnt_reg, rd_gnt_reg;

  logic [1:0]                   elig, win;
  logic                         start, issue;
  logic [PTR_W-1:0]             sel_ptr;
  logic [ADDR_FULL_W-1:0]       full_addr;
  logic [MIG_ADDR_W-1:0]        addr_next;

  // Status is taken from registered state only.
  assign empty = (level_reg == '0);
  assign full  = (level_reg == LEVEL_MAX);
  assign level = level_reg;

  assign elig  = {rd_req && !empty, wr_req && !full};
  assign start = (state_reg == S_IDLE) && calib_done && (elig != 2'b00);
  assign issue = (state_reg == S_ISSUE) && !mig.p0_cmd_full;

  ddr2_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .advance (start),
    .win     (win)
  );

  // Byte address of the winning pointer: zero-extend or truncate to the MIG width.
  assign sel_ptr   = win[1] ? rd_ptr_reg : wr_ptr_reg;
  assign full_addr = {sel_ptr, {OFS_W{1'b0}}};
  for (genvar gi = 0; gi < MIG_ADDR_W; gi++) begin : g_addr
    if (gi < ADDR_FULL_W) begin : g_bit
      assign addr_next[gi] = full_addr[gi];
    end else begin : g_zero
      assign addr_next[gi] = 1'b0;
    end
  end

  // Next-state logic: IDLE -> ISSUE on an eligible request, ISSUE -> HOLD once the MIG accepts, HOLD -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_ISSUE;
      S_ISSUE: if (!mig.p0_cmd_full) state_next = S_HOLD;
      S_HOLD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, latched command, registered strobes, pointers and level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      is_rd_reg  <= 1'b0;
      instr_reg  <= INSTR_WR;
      addr_reg   <= '0;
      cmd_en_reg <= 1'b0;
      wr_gnt_reg <= 1'b0;
      rd_gnt_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cmd_en_reg <= issue;
      wr_gnt_reg <= issue && !is_rd_reg;
      rd_gnt_reg <= issue && is_rd_reg;
      if (start) begin
        is_rd_reg <= win[1];
        instr_reg <= win[1] ? INSTR_RD : INSTR_WR;
        addr_reg  <= addr_next;
      end
      if (issue) begin
        if (is_rd_reg) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          level_reg  <= level_reg - 1'b1;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          level_reg  <= level_reg + 1'b1;
        end
      end
    end
  end

  assign mig.p0_cmd_en        = cmd_en_reg;
  assign mig.p0_cmd_instr     = instr_reg;
  assign mig.p0_cmd_byte_addr = addr_reg;
  assign mig.p0_cmd_bl        = BL_VAL;
  assign wr_gnt               = wr_gnt_reg;
  assign rd_gnt               = rd_gnt_reg;

`ifdef DDR2_SCHED_STATS_EN
  logic [31:0] wr_bursts_reg, rd_bursts_reg, stall_cycles_reg;

  // Saturating counters for granted bursts and for cycles blocked by a full MIG command FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bursts_reg    <= '0;
      rd_bursts_reg    <= '0;
      stall_cycles_reg <= '0;
    end else begin
      if (wr_gnt_reg && (wr_bursts_reg != '1)) wr_bursts_reg <= wr_bursts_reg + 1'b1;
      if (rd_gnt_reg && (rd_bursts_reg != '1)) rd_bursts_reg <= rd_bursts_reg + 1'b1;
      if ((state_reg == S_ISSUE) && mig.p0_cmd_full && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign wr_bursts    = wr_bursts_reg;
  assign rd_bursts    = rd_bursts_reg;
  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_ddr2_burst_scheduler.sv
// Directed testbench for ddr2_burst_scheduler.
// It drives two instances: A uses the default PTR_W=20 and B uses PTR_W=2.
// The B instance exercises the full and wrap boundaries.
module tb_ddr2_burst_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, calib_done, wr_req, rd_req, sel_b, cmd_full;

  ddr2_burst_scheduler_if mig_a ();
  ddr2_burst_scheduler_if mig_b ();
  assign mig_a.p0_cmd_full = cmd_full & ~sel_b;
  assign mig_b.p0_cmd_full = cmd_full & sel_b;

  logic        wr_gnt_a, rd_gnt_a, full_a, empty_a;
  logic        wr_gnt_b, rd_gnt_b, full_b, empty_b;
  logic [20:0] level_a;
  logic [2:0]  level_b;
`ifdef DDR2_SCHED_STATS_EN
  logic [31:0] wrb_a, rdb_a, stall_a, wrb_b, rdb_b, stall_b;
`endif

  ddr2_burst_scheduler u_dut_a (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .wr_req(wr_req & ~sel_b), .wr_gnt(wr_gnt_a),
    .rd_req(rd_req & ~sel_b), .rd_gnt(rd_gnt_a),
    .mig(mig_a), .level(level_a), .full(full_a), .empty(empty_a)
`ifdef DDR2_SCHED_STATS_EN
    , .wr_bursts(wrb_a), .rd_bursts(rdb_a), .stall_cycles(stall_a)
`endif
  );

  ddr2_burst_scheduler #(.BURST_LEN(32), .PTR_W(2), .OFS_W(7)) u_dut_b (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .wr_req(wr_req & sel_b), .wr_gnt(wr_gnt_b),
    .rd_req(rd_req & sel_b), .rd_gnt(rd_gnt_b),
    .mig(mig_b), .level(level_b), .full(full_b), .empty(empty_b)
`ifdef DDR2_SCHED_STATS_EN
    , .wr_bursts(wrb_b), .rd_bursts(rdb_b), .stall_cycles(stall_b)
`endif
  );

  // Observe whichever instance is currently selected.
  logic        cmd_en_m, wr_gnt_m, rd_gnt_m, full_m, empty_m;
  logic [2:0]  instr_m;
  logic [29:0] addr_m;
  logic [5:0]  bl_m;
  logic [20:0] level_m;
  assign cmd_en_m = sel_b ? mig_b.p0_cmd_en        : mig_a.p0_cmd_en;
  assign instr_m  = sel_b ? mig_b.p0_cmd_instr     : mig_a.p0_cmd_instr;
  assign addr_m   = sel_b ? mig_b.p0_cmd_byte_addr : mig_a.p0_cmd_byte_addr;
  assign bl_m     = sel_b ? mig_b.p0_cmd_bl        : mig_a.p0_cmd_bl;
  assign wr_gnt_m = sel_b ? wr_gnt_b : wr_gnt_a;
  assign rd_gnt_m = sel_b ? rd_gnt_b : rd_gnt_a;
  assign full_m   = sel_b ? full_b   : full_a;
  assign empty_m  = sel_b ? empty_b  : empty_a;
  assign level_m  = sel_b ? {18'd0, level_b} : level_a;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic        exp_rd;
    logic [29:0] exp_addr;
    int          exp_level;
    logic        on_b;
  } vec_t;

  vec_t vecs[22];

  // Apply one request pattern, wait a bounded time for the command, and check it.
  task automatic issue_one(input int idx);
    int waited;
    vec_t v;
    v = vecs[idx];
    waited = 0;
    wr_req = v.wr;
    rd_req = v.rd;
    do begin
      @(negedge clk);
      waited++;
    end while (cmd_en_m !== 1'b1 && waited < 20);
    if (cmd_en_m !== 1'b1) begin
      check($sformatf("v%0d cmd_en timeout", idx), {63'd0, cmd_en_m}, 64'd1);
    end else begin
      $display("txn v%0d dut=%s instr=%0d addr=0x%08h wr_gnt=%0b rd_gnt=%0b level=%0d",
               idx, v.on_b ? "B" : "A", instr_m, addr_m, wr_gnt_m, rd_gnt_m, level_m);
      check($sformatf("v%0d instr", idx), {61'd0, instr_m}, {63'd0, v.exp_rd});
      check($sformatf("v%0d addr", idx), {34'd0, addr_m}, {34'd0, v.exp_addr});
      check($sformatf("v%0d wr_gnt", idx), {63'd0, wr_gnt_m}, {63'd0, ~v.exp_rd});
      check($sformatf("v%0d rd_gnt", idx), {63'd0, rd_gnt_m}, {63'd0, v.exp_rd});
      check($sformatf("v%0d level", idx), {43'd0, level_m}, 64'(v.exp_level));
      check($sformatf("v%0d bl", idx), {58'd0, bl_m}, 64'd31);
      check($sformatf("v%0d empty", idx), {63'd0, empty_m}, {63'd0, v.exp_level == 0});
    end
  endtask

  // Hold a request that must be refused for a number of cycles.
  task automatic expect_blocked(input string name, input logic w, input logic r);
    logic seen;
    seen = 1'b0;
    wr_req = w;
    rd_req = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_en_m !== 1'b0) seen = 1'b1;
    end
    $display("txn %s blocked cmd_seen=%0b level=%0d", name, seen, level_m);
    check({name, " no cmd_en"}, {63'd0, seen}, 64'd0);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    logic bad;
    // Expected results are worked out by hand from the FIFO pointer arithmetic (addr = ptr * 128).
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 30'h080, 2, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 30'h100, 3, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 30'h180, 4, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 30'h000, 3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 30'h080, 2, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 30'h100, 1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 30'h180, 0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 30'h200, 1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 30'h280, 2, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 30'h300, 3, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 30'h200, 2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 30'h380, 3, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 30'h280, 2, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 30'h400, 3, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 30'h300, 2, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 30'h000, 1, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 30'h080, 2, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 30'h100, 3, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 30'h180, 4, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 30'h000, 3, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 30'h000, 4, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 30'h080, 3, 1'b1};

    reset = 1'b1; calib_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    sel_b = 1'b0; cmd_full = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn reset cmd_en=%0b level=%0d empty=%0b full=%0b", cmd_en_m, level_m, empty_m, full_m);
    check("reset cmd_en", {63'd0, cmd_en_m}, 64'd0);
    check("reset level", {43'd0, level_m}, 64'd0);
    check("reset empty", {63'd0, empty_m}, 64'd1);
    check("reset full", {63'd0, full_m}, 64'd0);
    check("reset instr", {61'd0, instr_m}, 64'd0);
    check("reset addr", {34'd0, addr_m}, 64'd0);

    // While calibration is incomplete no command may issue.
    reset = 1'b0;
    wr_req = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_en_m !== 1'b0 || wr_gnt_m !== 1'b0) bad = 1'b1;
    end
    $display("txn calib_off strobe_seen=%0b empty=%0b", bad, empty_m);
    check("calib_off no cmd_en", {63'd0, bad}, 64'd0);
    check("calib_off empty", {63'd0, empty_m}, 64'd1);
    check("calib_off addr", {34'd0, addr_m}, 64'd0);
    wr_req = 1'b0;
    calib_done = 1'b1;
    repeat (2) @(negedge clk);

    // The first write is issued exactly two cycles after the request is seen.
    wr_req = 1'b1;
    @(negedge clk);
    check("lat cycle1 cmd_en", {63'd0, cmd_en_m}, 64'd0);
    @(negedge clk);
    $display("txn first_write cmd_en=%0b instr=%0d addr=0x%08h level=%0d", cmd_en_m, instr_m, addr_m, level_m);
    check("lat cycle2 cmd_en", {63'd0, cmd_en_m}, 64'd1);
    check("lat wr_gnt", {63'd0, wr_gnt_m}, 64'd1);
    check("lat instr", {61'd0, instr_m}, 64'd0);
    check("lat addr", {34'd0, addr_m}, 64'd0);
    check("lat level", {43'd0, level_m}, 64'd1);
    @(negedge clk);
    check("lat gnt pulse", {63'd0, wr_gnt_m}, 64'd0);

    for (int i = 0; i <= 6; i++) issue_one(i);
    expect_blocked("empty_rd", 1'b0, 1'b1);
    for (int i = 7; i <= 14; i++) issue_one(i);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);

    // Hold the MIG command FIFO full for ten cycles while in ISSUE.
    cmd_full = 1'b1;
    wr_req = 1'b1;
    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_en_m !== 1'b0 || addr_m !== 30'h480) bad = 1'b1;
    end
    check("stall held", {63'd0, bad}, 64'd0);
    cmd_full = 1'b0;
    @(negedge clk);
    $display("txn stall_release cmd_en=%0b addr=0x%08h level=%0d", cmd_en_m, addr_m, level_m);
    check("stall release cmd_en", {63'd0, cmd_en_m}, 64'd1);
    check("stall release addr", {34'd0, addr_m}, 64'h480);
    check("stall release level", {43'd0, level_m}, 64'd3);
`ifdef DDR2_SCHED_STATS_EN
    check("stall_cycles", {32'd0, stall_a}, 64'd10);
`endif
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
`ifdef DDR2_SCHED_STATS_EN
    check("wr_bursts", {32'd0, wrb_a}, 64'd10);
    check("rd_bursts", {32'd0, rdb_a}, 64'd7);
`endif

    // Switch to the 4-burst instance to exercise full and pointer wrap.
    sel_b = 1'b1;
    @(negedge clk);
    for (int i = 15; i <= 18; i++) issue_one(i);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    check("B full", {63'd0, full_m}, 64'd1);
    expect_blocked("full_wr", 1'b1, 1'b0);
    check("B still full", {63'd0, full_m}, 64'd1);
    for (int i = 19; i <= 21; i++) issue_one(i);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
